// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : IF/LS requester ports and MEMORY drive for mem_arbiter
// Revision 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [WIDTH-1:0]      if_rdata_o;

  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [ADDR_WIDTH-1:0] ls_addr_i;
  logic [WIDTH-1:0]      ls_wdata_i;
  logic                  ls_gnt_o;
  logic                  ls_rvalid_o;
  logic [WIDTH-1:0]      ls_rdata_o;
  logic                  ls_err_o;

  logic                  memread_o;
  logic                  memwrite_o;
  logic [ADDR_WIDTH-1:0] memaddr_o;
  logic [WIDTH-1:0]      memwdata_o;
  logic [WIDTH-1:0]      memrdata_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    output memread_o, memwrite_o, memaddr_o, memwdata_o,
    input  memrdata_i
  );

  // Requesters plus MEMORY, seen from outside the arbiter
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    input  memread_o, memwrite_o, memaddr_o, memwdata_o,
    output memrdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares single-ported MEMORY between IF and LS, LS priority
//               with IF starvation guard, DRAM-window write protection
// Revision 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mem_arbiter_if.slave bus
);
  localparam int                    c_CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0]    c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] c_DRAM_LO    = ADDR_WIDTH'(4096);
  localparam logic [ADDR_WIDTH-1:0] c_DRAM_HI    = ADDR_WIDTH'(8192);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t                r_rsp_owner;
  owner_t                w_rsp_owner_nxt;
  logic [c_CNT_W-1:0]    r_starve_cnt;
  logic [c_CNT_W-1:0]    w_starve_cnt_nxt;
  logic                  r_ls_err;
  logic                  w_ls_err_nxt;

  logic                  w_starved;
  logic                  w_in_window;
  logic                  w_if_gnt;
  logic                  w_ls_gnt;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [WIDTH-1:0]      w_mem_wdata;

  // Grants depend only on requests, reset and the starvation count
  assign w_starved   = (r_starve_cnt == c_STARVE_MAX);
  assign w_in_window = (bus.ls_addr_i >= c_DRAM_LO) && (bus.ls_addr_i < c_DRAM_HI);
  assign w_ls_gnt    = rst_n && bus.ls_req_i && !(bus.if_req_i && w_starved);
  assign w_if_gnt    = rst_n && bus.if_req_i && !w_ls_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_owner  <= OWN_NONE;
      r_starve_cnt <= '0;
      r_ls_err     <= 1'b0;
    end else begin
      r_rsp_owner  <= w_rsp_owner_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_ls_err     <= w_ls_err_nxt;
    end
  end

  always_comb begin
    w_rsp_owner_nxt  = OWN_NONE;
    w_starve_cnt_nxt = '0;
    w_ls_err_nxt     = 1'b0;
    w_mem_read       = 1'b0;
    w_mem_write      = 1'b0;
    w_mem_addr       = '0;
    w_mem_wdata      = '0;

    if (rst_n) begin
      w_mem_wdata = bus.ls_wdata_i;
      if (w_if_gnt) begin
        w_mem_read      = 1'b1;
        w_mem_addr      = bus.if_addr_i;
        w_rsp_owner_nxt = OWN_IF;
      end else if (w_ls_gnt) begin
        w_mem_addr = bus.ls_addr_i;
        if (bus.ls_we_i) begin
          // Out-of-window writes are accepted but never reach MEMORY
          w_mem_write  = w_in_window;
          w_ls_err_nxt = !w_in_window;
        end else begin
          w_mem_read      = 1'b1;
          w_rsp_owner_nxt = OWN_LS;
        end
      end

      if (bus.if_req_i && w_ls_gnt) begin
        w_starve_cnt_nxt = w_starved ? r_starve_cnt : r_starve_cnt + 1'b1;
      end
    end
  end

  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.ls_gnt_o    = w_ls_gnt;
  assign bus.memread_o   = w_mem_read;
  assign bus.memwrite_o  = w_mem_write;
  assign bus.memaddr_o   = w_mem_addr;
  assign bus.memwdata_o  = w_mem_wdata;

  assign bus.if_rvalid_o = (r_rsp_owner == OWN_IF);
  assign bus.ls_rvalid_o = (r_rsp_owner == OWN_LS);
  assign bus.if_rdata_o  = bus.memrdata_i;
  assign bus.ls_rdata_o  = bus.memrdata_i;
  assign bus.ls_err_o    = r_ls_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed + randomized bench for mem_arbiter with a MEMORY stand-in
// Revision 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input logic [13:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  // MEMORY stand-in: one-cycle read latency, unwritten words show their preset content
  logic [31:0] fmem     [0:16383];
  bit          fwritten [0:16383];
  logic [13:0] fidx;
  assign fidx = bus.memaddr_o[13:0];
  always @(posedge clk) begin
    if (bus.memread_o)
      bus.memrdata_i <= fwritten[fidx] ? fmem[fidx] : init_word(fidx);
    if (bus.memwrite_o) begin
      fmem[fidx]     <= bus.memwdata_o;
      fwritten[fidx] <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expected memory image, pending response, waiting count, error pulse
  logic [31:0] shadow [0:16383];
  int          m_wait = 0;
  int          m_pend = 0;   // 0 none, 1 IF, 2 LS
  logic [31:0] m_pend_data = '0;
  bit          m_err = 1'b0;

  task automatic run_cycle(input logic rn, input logic ireq, input logic [31:0] iaddr,
                           input logic lreq, input logic lwe, input logic [31:0] laddr,
                           input logic [31:0] wdata, output logic [1:0] gnt_seen);
    bit e_if, e_ls, in_win, e_rd, e_wr;
    @(negedge clk);
    rst_n          = rn;
    bus.if_req_i   = ireq;
    bus.if_addr_i  = iaddr;
    bus.ls_req_i   = lreq;
    bus.ls_we_i    = lwe;
    bus.ls_addr_i  = laddr;
    bus.ls_wdata_i = wdata;
    #1;
    in_win = (laddr >= 32'd4096) && (laddr < 32'd8192);
    e_ls   = rn && lreq && !(ireq && m_wait >= LIMIT);
    e_if   = rn && ireq && !e_ls;
    e_rd   = e_if || (e_ls && !lwe);
    e_wr   = e_ls && lwe && in_win;
    chk("if_gnt",   64'(bus.if_gnt_o),   64'(e_if));
    chk("ls_gnt",   64'(bus.ls_gnt_o),   64'(e_ls));
    chk("memread",  64'(bus.memread_o),  64'(e_rd));
    chk("memwrite", 64'(bus.memwrite_o), 64'(e_wr));
    if (!rn) begin
      chk("memaddr_rst",  64'(bus.memaddr_o),  64'(0));
      chk("memwdata_rst", 64'(bus.memwdata_o), 64'(0));
    end else if (e_if) begin
      chk("memaddr_if", 64'(bus.memaddr_o), 64'(iaddr));
    end else if (e_ls) begin
      chk("memaddr_ls", 64'(bus.memaddr_o), 64'(laddr));
      if (lwe) chk("memwdata", 64'(bus.memwdata_o), 64'(wdata));
    end
    chk("if_rvalid", 64'(bus.if_rvalid_o), 64'(m_pend == 1));
    chk("ls_rvalid", 64'(bus.ls_rvalid_o), 64'(m_pend == 2));
    if (m_pend == 1) chk("if_rdata", 64'(bus.if_rdata_o), 64'(m_pend_data));
    if (m_pend == 2) chk("ls_rdata", 64'(bus.ls_rdata_o), 64'(m_pend_data));
    chk("ls_err", 64'(bus.ls_err_o), 64'(m_err));
    gnt_seen = {bus.if_gnt_o, bus.ls_gnt_o};
    @(posedge clk);
    if (!rn) begin
      m_pend = 0;
      m_wait = 0;
      m_err  = 1'b0;
    end else begin
      m_err = e_ls && lwe && !in_win;
      if (e_if) begin
        m_pend = 1;
        m_pend_data = shadow[iaddr[13:0]];
      end else if (e_ls && !lwe) begin
        m_pend = 2;
        m_pend_data = shadow[laddr[13:0]];
      end else begin
        m_pend = 0;
      end
      if (e_wr) shadow[laddr[13:0]] = wdata;
      m_wait = (ireq && e_ls) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
    end
  endtask

  function automatic logic [31:0] rand_addr(input bit ls_side);
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0 || (!ls_side && sel == 1)) return 32'($urandom_range(0, 4095));
    if (sel == 3) return 32'($urandom_range(8192, 16383));
    return 32'(4096 + 4 * $urandom_range(0, 31));
  endfunction

  logic [1:0]  g;
  logic        ir, lr, lw, rn;
  logic [31:0] ia, la, ld;

  initial begin
    for (int i = 0; i < 16384; i++) shadow[i] = init_word(14'(i));
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_addr_i = '0; bus.ls_wdata_i = '0;

    // Reset with both ports requesting: everything held quiet
    run_cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h1000, 32'h5, g);
    chk("rst_gnts", 64'(g), 64'(0));
    run_cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h1000, 32'h5, g);

    // IF-only read of 0x10
    run_cycle(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, g);
    chk("if_only_gnt", 64'(g), 64'h2);
    #2;
    chk("if_read_valid", 64'({bus.if_rvalid_o, bus.ls_rvalid_o}), 64'h2);
    chk("if_read_data", 64'(bus.if_rdata_o), 64'(init_word(14'h10)));

    // LS write then read back in DRAM
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1004, 32'hDEADBEEF, g);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1004, 32'h0, g);
    #2;
    chk("ls_rd_valid", 64'(bus.ls_rvalid_o), 64'(1));
    chk("ls_rd_data", 64'(bus.ls_rdata_o), 64'h0000_0000_DEAD_BEEF);

    // Out-of-window writes: accepted, dropped, error pulse next cycle
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0800, 32'h1111_1111, g);
    chk("oow_lo_gnt", 64'(g), 64'h1);
    #2 chk("oow_lo_err", 64'(bus.ls_err_o), 64'(1));
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h2222_2222, g);
    #2 chk("oow_hi_err", 64'(bus.ls_err_o), 64'(1));
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0800, 32'h0, g);
    #2;
    chk("oow_err_clear", 64'(bus.ls_err_o), 64'(0));
    chk("irom_unchanged", 64'(bus.ls_rdata_o), 64'(init_word(14'h0800)));

    // Both requesting every cycle: LS x4 then IF, repeating
    run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 32'(4096 + i * 4), 32'h0, g);
      chk("starve_seq", 64'(g), (i % 5 == 4) ? 64'h2 : 64'h1);
    end

    // Reset while an LS read is outstanding; starvation count restarts
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1004, 32'h0, g);
    run_cycle(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h1008, 32'h0, g);
    chk("rst_mid_gnts", 64'(g), 64'(0));
    #2 chk("rst_drop_rvalid", 64'(bus.ls_rvalid_o), 64'(0));
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 1'b1, 32'(i * 8), 1'b1, 1'b0, 32'(4096 + i * 8), 32'h0, g);
      chk("starve_after_rst", 64'(g), (i == 4) ? 64'h2 : 64'h1);
    end

    // Alternating single requests with idle gaps
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 1'b1, 32'(i * 12), 1'b0, 1'b0, 32'h0, 32'h0, g);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1, i[0], 32'(4096 + i * 4), $urandom, g);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
    end

    // Randomized traffic; requesters mostly hold until granted
    ir = 1'b0; lr = 1'b0; lw = 1'b0; ia = '0; la = '0; ld = '0; g = '0;
    for (int c = 0; c < 800; c++) begin
      rn = ($urandom_range(0, 99) >= 2);
      if (!ir || g[1] || $urandom_range(0, 9) == 0) begin
        ir = ($urandom_range(0, 99) < 65);
        ia = rand_addr(1'b0);
      end
      if (!lr || g[0] || $urandom_range(0, 9) == 0) begin
        lr = ($urandom_range(0, 99) < 65);
        lw = 1'($urandom_range(0, 1));
        la = rand_addr(1'b1);
        ld = $urandom;
      end
      run_cycle(rn, ir, ia, lr, lw, la, ld, g);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported unified MEMORY block (IROM at 0–4095, DRAM at 4096–8191) between the instruction-fetch unit (IF port) and the load/store unit (LS port). Accepts at most one access per cycle, drives MEMORY's read/write/address/write-data inputs, and routes the one-cycle-late read data back to the port that issued the read. Applies fixed priority to LS with a starvation guard for IF, and blocks LS writes outside the DRAM window.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width, matches MEMORY.
- WIDTH, 32, data width, matches MEMORY.
- STARVE_LIMIT, 4, consecutive LS wins over a pending IF request before IF is forced through (≥1).

Ports:
- clk  in  1  single clock; everything is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req_i  in  1  IF read request.
- if_addr_i  in  ADDR_WIDTH  IF read address.
- if_gnt_o  out  1  IF request accepted this cycle (combinational).
- if_rvalid_o  out  1  if_rdata_o valid (registered ownership).
- if_rdata_o  out  WIDTH  read data for IF.
- ls_req_i  in  1  LS request.
- ls_we_i  in  1  1 = write, 0 = read.
- ls_addr_i  in  ADDR_WIDTH  LS address.
- ls_wdata_i  in  WIDTH  LS write data.
- ls_gnt_o  out  1  LS request accepted this cycle (combinational).
- ls_rvalid_o  out  1  ls_rdata_o valid.
- ls_rdata_o  out  WIDTH  read data for LS.
- ls_err_o  out  1  one-cycle pulse: previously granted write was outside 4096–8191 and was dropped.
- memread_o, memwrite_o  out  1  to MEMORY memread_i/memwrite_i.
- memaddr_o  out  ADDR_WIDTH  to MEMORY memaddr_i.
- memwdata_o  out  WIDTH  to MEMORY memwdata_i.
- memrdata_i  in  WIDTH  from MEMORY memrdata_o.

## Operation
- Grant decision per cycle, while rst_n=1:
  - LS only requesting → LS granted. IF only requesting → IF granted.
  - Both requesting → LS granted unless starve_cnt == STARVE_LIMIT, in which case IF is granted.
  - Neither requesting → no grant; memread_o = memwrite_o = 0.
- starve_cnt, range 0..STARVE_LIMIT:
  - Increments, saturating, when LS wins and IF was requesting.
  - Clears when IF is granted or if_req_i=0.
- Mem drive in the grant cycle:
  - memaddr_o = address of the granted port. memwdata_o = ls_wdata_i.
  - memread_o = 1 for an IF grant or an LS read grant.
  - memwrite_o = 1 only for an LS write grant with 4096 ≤ ls_addr_i < 8192.
- Out-of-window LS write: still granted (ls_gnt_o=1), memwrite_o=0, ls_err_o=1 in the next cycle.
- Response owner register rsp_owner ∈ {NONE, IF, LS}: loaded each cycle with the port granted a read, or NONE otherwise.
  - if_rvalid_o = (rsp_owner==IF); ls_rvalid_o = (rsp_owner==LS).
  - if_rdata_o and ls_rdata_o both carry memrdata_i; rvalid qualifies them.
- Writes produce no rvalid; acceptance is signalled by the grant.

## Timing
- Read latency: grant in cycle N → rvalid and data in cycle N+1.
- Throughput is one access per cycle, and back-to-back reads from either or both ports are legal.
- Cycle N+1 may simultaneously carry the rvalid for access N and the grant for access N+1.
- Requesters hold req/addr/wdata until they see gnt. Dropping req without a grant is allowed and has no side effects.
- Grants are combinational from req, rst_n and starve_cnt. No combinational path from memrdata_i to any grant.
- Reset, sampled at the clock edge while rst_n=0:
  - rsp_owner=NONE, starve_cnt=0, ls_err_o=0.
  - While rst_n=0, the grants and memread_o/memwrite_o are forced to 0, and memaddr_o and memwdata_o are 0.
- Reset during an outstanding read: the read is discarded, and rvalid is 0 in the cycle after reset.
- Addresses ≥ 8192: reads are passed through unchanged (data is whatever MEMORY returns). Writes follow the out-of-window rule.

## Test plan
- IF-only read of 0x0000_0010 → if_gnt_o=1 same cycle, memread_o=1, memaddr_o=0x10; next cycle if_rvalid_o=1, if_rdata_o=IROM word, ls_rvalid_o=0.
- LS write 0xDEADBEEF to 0x1004, then LS read 0x1004 next cycle → memwrite_o=1 then memread_o=1; one cycle after the read, ls_rvalid_o=1 with ls_rdata_o=0xDEADBEEF.
- IF and LS requesting every cycle, STARVE_LIMIT=4 → grant sequence LS,LS,LS,LS,IF repeating. Each rvalid lands on the correct port one cycle after its grant.
- LS write to 0x0800, then to 0x2000 → both granted, memwrite_o=0 for each, ls_err_o pulses 1 in the following cycle. A later read of 0x0800 returns the unchanged IROM word.
- LS read granted in cycle N, rst_n=0 in cycle N+1 → ls_rvalid_o=0 after reset, all grants 0 while in reset, starve_cnt restarts at 0.
- Alternating IF/LS single requests with idle gaps → no spurious rvalid on idle cycles, and memread_o=memwrite_o=0 on idle cycles.
